// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
//   Request/response bundle between two requesters and the ALU arbiter.
//   master : requester side (drives reqN_valid/oc/a/b and rspN_ready)
//   slave  : arbiter side   (drives reqN_ready, rspN_valid, rsp_data, rsp_err)
//   Signals:
//     reqN_valid/ready  request handshake for port N (N = 0, 1)
//     reqN_oc/a/b       opcode and operands for port N
//     rspN_valid/ready  response handshake for port N
//     rsp_data/rsp_err  shared result and divide-by-zero flag
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [2:0]            req0_oc;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [2:0]            req1_oc;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;
  logic                  rsp0_valid;
  logic                  rsp0_ready;
  logic                  rsp1_valid;
  logic                  rsp1_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  modport master (
    output req0_valid, req0_oc, req0_a, req0_b,
    output req1_valid, req1_oc, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req0_valid, req0_oc, req0_a, req0_b,
    input  req1_valid, req1_oc, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one external combinational ALU between two requesters. Round-robin
//   arbitration in IDLE, one EXEC cycle driving the ALU from latched operands,
//   then the registered result is offered to the granted port in RESP until it
//   is consumed.
//   Ports:
//     clk, rst_n         clock (rising edge), asynchronous active-low reset
//     bus                request/response bundle (slave side)
//     alu_oc/alu_a/alu_b operands to the external ALU (from operand registers)
//     alu_f              result from the external ALU
module alu_arbiter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_arbiter_if.slave          bus,
  output logic [2:0]            alu_oc,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_f
);

  localparam logic [2:0] OC_DIV = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_reg;
  state_t                state_next;
  logic                  ptr_reg;        // port favoured when both request
  logic                  gnt_reg;        // port owning the in-flight op
  logic [2:0]            oc_reg;
  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] b_reg;
  logic [DATA_WIDTH-1:0] rsp_data_reg;
  logic                  rsp_err_reg;

  logic any_valid;
  logic grant;
  logic accept;
  logic rsp_ready_sel;
  logic div_zero;

  assign any_valid = bus.req0_valid | bus.req1_valid;
  // Pointer only matters under contention; otherwise the lone requester wins.
  assign grant     = (bus.req0_valid & bus.req1_valid) ? ptr_reg : bus.req1_valid;
  assign accept    = (state_reg == IDLE) & any_valid;
  // Ready from the port that does not own the response is ignored.
  assign rsp_ready_sel = gnt_reg ? bus.rsp1_ready : bus.rsp0_ready;
  assign div_zero  = (oc_reg == OC_DIV) && (b_reg == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_valid) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready_sel) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs; ready is also held low while reset is asserted.
  always_comb begin
    bus.req0_ready = rst_n & accept & ~grant;
    bus.req1_ready = rst_n & accept & grant;
    bus.rsp0_valid = (state_reg == RESP) & ~gnt_reg;
    bus.rsp1_valid = (state_reg == RESP) & gnt_reg;
  end

  // Operand capture, grant bookkeeping and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= 1'b0;
      gnt_reg <= 1'b0;
      oc_reg  <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
    end else begin
      if (accept) begin
        gnt_reg <= grant;
        oc_reg  <= grant ? bus.req1_oc : bus.req0_oc;
        a_reg   <= grant ? bus.req1_a  : bus.req0_a;
        b_reg   <= grant ? bus.req1_b  : bus.req0_b;
      end
      if ((state_reg == RESP) && rsp_ready_sel) begin
        ptr_reg <= ~gnt_reg;
      end
    end
  end

  // Result capture at the end of EXEC; held stable through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
    end else if (state_reg == EXEC) begin
      // A zero divisor always reports data 0, whatever the ALU drives.
      rsp_data_reg <= div_zero ? '0 : alu_f;
      rsp_err_reg  <= div_zero;
    end
  end

  assign bus.rsp_data = rsp_data_reg;
  assign bus.rsp_err  = rsp_err_reg;
  assign alu_oc       = oc_reg;
  assign alu_a        = a_reg;
  assign alu_b        = b_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Self-checking bench for alu_arbiter with a stand-in ALU and a reference
//   model of the arithmetic and round-robin grant order.
module tb_alu_arbiter;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    alu_oc;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_f;

  int checks = 0;
  int failures = 0;
  int exp_ptr = 0;

  alu_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  alu_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .alu_oc (alu_oc),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_f  (alu_f)
  );

  always #5 clk = ~clk;

  // Stand-in for the external combinational ALU
  always_comb begin
    case (alu_oc)
      3'd0:    alu_f = alu_a + alu_b;
      3'd1:    alu_f = alu_a - alu_b;
      3'd2:    alu_f = alu_a * alu_b;
      3'd3:    alu_f = (alu_b == '0) ? '0 : alu_a / alu_b;
      3'd4:    alu_f = ~alu_a;
      3'd5:    alu_f = alu_a ^ alu_b;
      3'd6:    alu_f = alu_a | alu_b;
      default: alu_f = alu_a & alu_b;
    endcase
  end

  // Reference result {err, data} from plain integer arithmetic wrapped to DW bits
  function automatic logic [DW:0] ref_op(input logic [2:0] oc, input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
    longint la, lb, r, mask;
    logic err;
    la = longint'(a);
    lb = longint'(b);
    mask = (longint'(1) <<< DW) - 1;
    err = 1'b0;
    case (oc)
      3'd0: r = la + lb;
      3'd1: r = la - lb;
      3'd2: r = la * lb;
      3'd3: begin
        if (lb == 0) begin
          r = 0;
          err = 1'b1;
        end else begin
          r = la / lb;
        end
      end
      3'd4: r = mask - la;
      3'd5: r = la ^ lb;
      3'd6: r = la | lb;
      default: r = la & lb;
    endcase
    r = r & mask;
    return {err, r[DW-1:0]};
  endfunction

  function automatic logic rdy(input int port);
    return (port == 1) ? bus.req1_ready : bus.req0_ready;
  endfunction

  function automatic logic rvalid(input int port);
    return (port == 1) ? bus.rsp1_valid : bus.rsp0_valid;
  endfunction

  task automatic set_req(input int port, input logic v, input logic [2:0] oc,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (port == 1) begin
      bus.req1_valid = v; bus.req1_oc = oc; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_oc = oc; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  task automatic set_rsp_ready(input int port, input logic v);
    if (port == 1) bus.rsp1_ready = v;
    else bus.rsp0_ready = v;
  endtask

  // One complete transaction on a single port with no contention
  task automatic run_op(input int port, input logic [2:0] oc, input logic [DW-1:0] a,
                        input logic [DW-1:0] b);
    logic [DW:0] e;
    e = ref_op(oc, a, b);
    @(posedge clk); #1;
    set_req(port, 1'b1, oc, a, b);
    @(negedge clk);
    checks++;
    if (rdy(port) !== 1'b1 || rdy(1 - port) !== 1'b0) begin
      failures++;
      $display("FAIL accept_p%0d ready=%b/%b required=1/0", port, rdy(port), rdy(1 - port));
    end
    @(posedge clk); #1;
    set_req(port, 1'b0, 3'd0, '0, '0);
    @(negedge clk);
    checks++;
    if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 || alu_oc !== oc ||
        alu_a !== a || alu_b !== b) begin
      failures++;
      $display("FAIL exec_p%0d valid=%b%b alu=%0d/%h/%h required=00 %0d/%h/%h", port,
               bus.rsp1_valid, bus.rsp0_valid, alu_oc, alu_a, alu_b, oc, a, b);
    end
    @(negedge clk);
    checks++;
    if (rvalid(port) !== 1'b1 || rvalid(1 - port) !== 1'b0 ||
        bus.rsp_data !== e[DW-1:0] || bus.rsp_err !== e[DW]) begin
      failures++;
      $display("FAIL resp_p%0d valid=%b/%b data=%h err=%b required=1/0 %h %b", port,
               rvalid(port), rvalid(1 - port), bus.rsp_data, bus.rsp_err, e[DW-1:0], e[DW]);
    end
    $display("txn port=%0d oc=%0d a=%h b=%h data=%h err=%b", port, oc, a, b,
             bus.rsp_data, bus.rsp_err);
    set_rsp_ready(port, 1'b1);
    @(posedge clk); #1;
    set_rsp_ready(port, 1'b0);
    exp_ptr = 1 - port;
    @(negedge clk);
    checks++;
    if (rvalid(port) !== 1'b0) begin
      failures++;
      $display("FAIL release_p%0d valid=%b required=0", port, rvalid(port));
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err} !== 5'b0 ||
        bus.rsp_data !== '0 || alu_oc !== 3'd0 || alu_a !== '0 || alu_b !== '0) begin
      failures++;
      $display("FAIL %s rdy=%b%b val=%b%b err=%b data=%h alu=%0d/%h/%h required all 0", name,
               bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.rsp_err,
               bus.rsp_data, alu_oc, alu_a, alu_b);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_req(0, 1'b1, 3'd0, 16'd3, 16'd4);
    set_req(1, 1'b0, 3'd0, '0, '0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_hold");
    set_req(0, 1'b0, 3'd0, '0, '0);
    rst_n = 1'b1;
    exp_ptr = 0;
    run_op(0, 3'd0, 16'd3, 16'd4);
  endtask

  task automatic test_directed();
    run_op(1, 3'd3, 16'd100, 16'd7);
    run_op(0, 3'd3, 16'd5, 16'd0);
    run_op(1, 3'd1, 16'd0, 16'd1);
    run_op(0, 3'd2, 16'hFFFF, 16'd2);
    run_op(1, 3'd4, 16'h00F0, 16'd0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      logic [DW-1:0] b;
      b = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
      run_op(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), DW'($urandom), b);
    end
  endtask

  // Both ports request continuously; grants must alternate starting at port 0
  task automatic test_contention();
    logic [2:0]    c_oc [2];
    logic [DW-1:0] c_a [2];
    logic [DW-1:0] c_b [2];
    logic [DW:0]   e;
    int            g;
    pulse_reset();
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    @(posedge clk); #1;
    for (int p = 0; p < 2; p++) begin
      c_oc[p] = 3'($urandom_range(0, 7)); c_a[p] = DW'($urandom); c_b[p] = DW'($urandom);
      set_req(p, 1'b1, c_oc[p], c_a[p], c_b[p]);
    end
    for (int t = 0; t < 8; t++) begin
      int waited;
      waited = 0;
      @(negedge clk);
      while (!(bus.req0_ready | bus.req1_ready) && waited < 4) begin
        @(negedge clk);
        waited++;
      end
      g = exp_ptr;
      checks++;
      if (rdy(g) !== 1'b1 || rdy(1 - g) !== 1'b0) begin
        failures++;
        $display("FAIL contention_grant t=%0d ready=%b%b required port %0d", t,
                 bus.req1_ready, bus.req0_ready, g);
        break;
      end
      e = ref_op(c_oc[g], c_a[g], c_b[g]);
      @(posedge clk); #1;
      c_oc[g] = 3'($urandom_range(0, 7)); c_a[g] = DW'($urandom); c_b[g] = DW'($urandom);
      set_req(g, 1'b1, c_oc[g], c_a[g], c_b[g]);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (rvalid(g) !== 1'b1 || rvalid(1 - g) !== 1'b0 ||
          bus.rsp_data !== e[DW-1:0] || bus.rsp_err !== e[DW]) begin
        failures++;
        $display("FAIL contention_resp t=%0d valid=%b%b data=%h err=%b required port %0d %h %b",
                 t, bus.rsp1_valid, bus.rsp0_valid, bus.rsp_data, bus.rsp_err, g,
                 e[DW-1:0], e[DW]);
      end
      $display("txn contention t=%0d port=%0d data=%h err=%b", t, g, bus.rsp_data, bus.rsp_err);
      exp_ptr = 1 - g;
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 3'd0, '0, '0);
    set_req(1, 1'b0, 3'd0, '0, '0);
    @(posedge clk); #1;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
  endtask

  task automatic test_back_pressure();
    logic [DW:0] e1;
    logic [DW:0] e0;
    e1 = ref_op(3'd2, 16'd300, 16'd300);
    e0 = ref_op(3'd5, 16'h1234, 16'hFF00);
    @(posedge clk); #1;
    set_req(1, 1'b1, 3'd2, 16'd300, 16'd300);
    @(negedge clk);
    @(posedge clk); #1;
    set_req(1, 1'b0, 3'd0, '0, '0);
    set_req(0, 1'b1, 3'd5, 16'h1234, 16'hFF00);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 || bus.req0_ready !== 1'b0 ||
          bus.rsp_data !== e1[DW-1:0]) begin
        failures++;
        $display("FAIL backpressure_hold i=%0d val=%b%b rdy0=%b data=%h required 10 0 %h", i,
                 bus.rsp1_valid, bus.rsp0_valid, bus.req0_ready, bus.rsp_data, e1[DW-1:0]);
      end
      @(posedge clk); #1;
      bus.rsp0_ready = (i == 1);
      @(negedge clk);
    end
    $display("txn backpressure port=1 data=%h err=%b", bus.rsp_data, bus.rsp_err);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp1_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rsp1_valid !== 1'b0 || bus.req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release rsp1_valid=%b req0_ready=%b required 0 1",
               bus.rsp1_valid, bus.req0_ready);
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 3'd0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp_data !== e0[DW-1:0] || bus.rsp_err !== e0[DW]) begin
      failures++;
      $display("FAIL backpressure_next valid=%b data=%h err=%b required 1 %h %b",
               bus.rsp0_valid, bus.rsp_data, bus.rsp_err, e0[DW-1:0], e0[DW]);
    end
    $display("txn port=0 data=%h err=%b", bus.rsp_data, bus.rsp_err);
    bus.rsp0_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp0_ready = 1'b0;
    exp_ptr = 1;
  endtask

  // phase 0: reset during EXEC, phase 1: reset during RESP
  task automatic test_reset_mid_op(input int phase);
    logic [DW:0] e;
    run_op(0, 3'd0, DW'($urandom), DW'($urandom));
    @(posedge clk); #1;
    set_req(1, 1'b1, 3'd7, 16'hABCD, 16'h0FF0);
    @(negedge clk);
    @(posedge clk); #1;
    set_req(1, 1'b0, 3'd0, '0, '0);
    @(negedge clk);
    if (phase == 1) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_ptr = 0;
    #1;
    check_all_zero(phase == 1 ? "reset_in_resp" : "reset_in_exec");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
        failures++;
        $display("FAIL stale_resp phase=%0d valid=%b%b required 00", phase,
                 bus.rsp1_valid, bus.rsp0_valid);
      end
    end
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    e = ref_op(3'd6, 16'h0F00, 16'h00F0);
    @(posedge clk); #1;
    set_req(0, 1'b1, 3'd6, 16'h0F00, 16'h00F0);
    set_req(1, 1'b1, 3'd0, 16'd1, 16'd1);
    @(negedge clk);
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_grant phase=%0d ready=%b%b required port 0", phase,
               bus.req1_ready, bus.req0_ready);
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 3'd0, '0, '0);
    set_req(1, 1'b0, 3'd0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0 || bus.rsp_data !== e[DW-1:0]) begin
      failures++;
      $display("FAIL post_reset_resp phase=%0d valid=%b%b data=%h required 01 %h", phase,
               bus.rsp1_valid, bus.rsp0_valid, bus.rsp_data, e[DW-1:0]);
    end
    $display("txn post-reset phase=%0d port=0 data=%h", phase, bus.rsp_data);
    bus.rsp0_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp0_ready = 1'b0;
    exp_ptr = 1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_contention();
    test_back_pressure();
    test_reset_mid_op(0);
    test_reset_mid_op(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired time=%0t required completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
